memory_system: RTL and testbench
================================

Name: memory_system

Overview:
- Memory-side responder for the 8-bit CPU bus: the CPU drives address, to_memory and write; this block returns read data on from_memory.
- Decodes the 8-bit address space into four regions:
  - program ROM, loadable through a side programming port
  - general RAM
  - output port registers
  - synchronized input ports
- Sits beside the cpu at the top level. Its from_memory drives the CPU's from_memory; the CPU's outputs drive its inputs.

Parameters:
- ROM_TOP, 8'h7F, last ROM address; ROM spans 0x00..ROM_TOP.
- RAM_TOP, 8'hDF, last RAM address; RAM spans ROM_TOP+1..RAM_TOP.
- NUM_OUT, 4, number of output port registers, mapped at 0xE0..0xE0+NUM_OUT-1 (max 16).
- NUM_IN, 4, number of input ports, mapped at 0xF0..0xF0+NUM_IN-1 (max 16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  8  CPU address bus.
- to_memory  input  8  CPU write data.
- write  input  1  CPU write strobe; 1 = write this cycle.
- from_memory  output  8  registered read data to the CPU.
- prog_we  input  1  ROM programming write enable.
- prog_addr  input  8  ROM programming address; ignored unless <= ROM_TOP.
- prog_data  input  8  ROM programming data.
- port_out  output  8*NUM_OUT  output port registers; port k occupies bits [8k+7:8k].
- port_in  input  8*NUM_IN  asynchronous external inputs, same packing as port_out.
- rom_write_err  output  1  sticky flag: the CPU attempted a write into ROM.

Behaviour:
- Reset, asynchronous and active-high, with the following effects:
  - from_memory = 8'h00.
  - All port_out registers = 8'h00.
  - rom_write_err = 0.
  - Both input synchronizer stages = 8'h00.
  - ROM and RAM contents are NOT cleared; they are retained across reset.
- Reset mid-operation: a write presented in the same cycle that reset is asserted is discarded.
- Read timing:
  - Read latency is 1 cycle.
  - On each rising edge with reset low, from_memory <= decode(address), regardless of write.
  - The CPU samples from_memory on the edge after it presents the address.
- Read-during-write to the same location returns the OLD value (read-before-write). The new value is visible on the next read.
- Read decode:
  - 0x00..ROM_TOP: ROM byte.
  - ROM_TOP+1..RAM_TOP: RAM byte.
  - 0xE0+k, k < NUM_OUT: readback of port_out[k].
  - 0xF0+k, k < NUM_IN: synchronized port_in[k].
  - All other addresses in 0xE0..0xFF: 8'h00.
- Write decode, when write=1 at a rising edge:
  - ROM region: no data change; rom_write_err <= 1 (sticky until reset).
  - RAM region: RAM[address] <= to_memory.
  - Output port k: port_out[k] <= to_memory.
  - Input ports and unmapped addresses: ignored, no flag set.
- Input synchronizer:
  - Each port_in byte passes through a 2-flop synchronizer.
  - A change on port_in becomes readable at the 2nd rising edge after the change.
  - from_memory reflects it on the read that samples at or after that edge.
- ROM programming:
  - On a rising edge with prog_we=1 and prog_addr <= ROM_TOP: ROM[prog_addr] <= prog_data.
  - With prog_addr > ROM_TOP: ignored.
  - Programming works regardless of the CPU bus state and never sets rom_write_err.
  - A simultaneous CPU read of the same ROM address returns the OLD byte.
- Simultaneous events:
  - A CPU write to a RAM or port address and prog_we in the same cycle both take effect; they target disjoint storage.
  - A CPU write to ROM together with prog_we: only prog_we changes ROM; the error flag is still set.
- Address wrap: none. The address is a full 8 bits and every value has a defined decode.
- Storage: ROM and RAM are inferred register arrays with a synchronous write port and a registered read.

Test Plan:
- Reset values:
  - Stimulus: assert reset with random bus activity.
  - Required: from_memory=00, port_out=0, rom_write_err=0.
  - Then: preload ROM[0x10]=0xA5 via prog_*, pulse reset, read 0x10 → from_memory=A5 one cycle later (ROM retained).
- RAM write/read:
  - Stimulus: write 0x3C to 0x80, then read 0x80.
  - Required: from_memory=3C on the edge after the read address.
  - Then: same-cycle read/write of 0x81, old 0x00 then new 0x77 → first read returns 00, next read returns 77.
- ROM protection:
  - Stimulus: write 0xFF to 0x05 holding 0x12.
  - Required: read 0x05 → 12; rom_write_err=1 and stays 1 until reset.
  - Then: prog_we with prog_addr=0x90 → RAM[0x90] unchanged.
- Output ports:
  - Stimulus: write 0x5A to 0xE2.
  - Required: port_out[23:16]=5A on the next edge; read 0xE2 → 5A.
  - Then: write to 0xE7 → no port changes; read 0xE7 → 00.
- Input synchronizer:
  - Stimulus: change port_in[7:0] to 0xC3 mid-cycle, read 0xF0 continuously.
  - Required: from_memory shows C3 no earlier than 3 edges and no later than 4 edges after the change; read 0xF9 → 00.
- Async reset mid-write:
  - Stimulus: assert reset between edges while write=1 to 0xE0 with data 0x99.
  - Required: port_out[7:0]=00 immediately; the write is discarded after reset release.

Source files
------------

// File: rtl/memory_system.sv
// memory_system: memory-side responder for the 8-bit CPU bus.
//
// Address map:
//   0x00 .. ROM_TOP          program ROM (CPU read-only, loaded via prog_*)
//   ROM_TOP+1 .. RAM_TOP     general RAM
//   0xE0 .. 0xE0+NUM_OUT-1   output port registers (read back)
//   0xF0 .. 0xF0+NUM_IN-1    2-flop synchronized input ports
//   other 0xE0..0xFF         read as 8'h00, writes ignored
//
// Ports:
//   clk, reset               clock and asynchronous active-high reset
//   address, to_memory       CPU address and write data
//   write                    CPU write strobe
//   from_memory              registered read data (1-cycle latency)
//   prog_we/addr/data        ROM programming port
//   port_out                 output port registers, port k at [8k+7:8k]
//   port_in                  asynchronous external inputs, same packing
//   rom_write_err            sticky flag: CPU tried to write ROM
module memory_system #(
  parameter logic [7:0] ROM_TOP = 8'h7F,
  parameter logic [7:0] RAM_TOP = 8'hDF,
  parameter int         NUM_OUT = 4,
  parameter int         NUM_IN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            address,
  input  logic [7:0]            to_memory,
  input  logic                  write,
  output logic [7:0]            from_memory,
  input  logic                  prog_we,
  input  logic [7:0]            prog_addr,
  input  logic [7:0]            prog_data,
  output logic [8*NUM_OUT-1:0]  port_out,
  input  logic [8*NUM_IN-1:0]   port_in,
  output logic                  rom_write_err
);

  localparam int         ROM_DEPTH = int'(ROM_TOP) + 1;
  localparam int         ROM_AW    = $clog2(ROM_DEPTH);
  localparam int         RAM_DEPTH = int'(RAM_TOP) - int'(ROM_TOP);
  localparam int         RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [7:0] RAM_BASE  = ROM_TOP + 8'd1;

  logic [7:0] rom [0:ROM_DEPTH-1];
  logic [7:0] ram [0:RAM_DEPTH-1];

  logic [7:0]          out_reg [NUM_OUT];
  logic [8*NUM_IN-1:0] sync1_reg;
  logic [8*NUM_IN-1:0] sync2_reg;

  logic              rom_hit;
  logic              ram_hit;
  logic [ROM_AW-1:0] rom_index;
  logic [RAM_AW-1:0] ram_index;
  logic [7:0]        read_next;

  assign rom_hit   = (address <= ROM_TOP);
  assign ram_hit   = !rom_hit && (address <= RAM_TOP);
  assign rom_index = address[ROM_AW-1:0];
  assign ram_index = RAM_AW'(address - RAM_BASE);

  // Storage arrays carry no reset so their contents survive it. A CPU write
  // coinciding with reset is dropped; programming is independent of the bus.
  always_ff @(posedge clk) begin
    if (prog_we && (prog_addr <= ROM_TOP))
      rom[prog_addr[ROM_AW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (write && ram_hit && !reset)
      ram[ram_index] <= to_memory;
  end

  // Read mux sees pre-edge array contents, giving read-before-write.
  always_comb begin
    read_next = 8'h00;
    if (rom_hit) begin
      read_next = rom[rom_index];
    end else if (ram_hit) begin
      read_next = ram[ram_index];
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (address == 8'(8'hE0 + k)) read_next = out_reg[k];
      for (int k = 0; k < NUM_IN; k++)
        if (address == 8'(8'hF0 + k)) read_next = sync2_reg[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      from_memory   <= 8'h00;
      rom_write_err <= 1'b0;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
    end else begin
      from_memory <= read_next;
      sync1_reg   <= port_in;
      sync2_reg   <= sync1_reg;
      if (write && rom_hit)
        rom_write_err <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      localparam logic [7:0] PORT_ADDR = 8'(8'hE0 + gi);
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          out_reg[gi] <= 8'h00;
        else if (write && (address == PORT_ADDR))
          out_reg[gi] <= to_memory;
      end
      assign port_out[8*gi +: 8] = out_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_memory_system.sv
// Directed testbench for memory_system: reset values, ROM retention and
// protection, RAM read-before-write, output ports, input synchronizer
// latency, and asynchronous reset during a write.
module tb_memory_system;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address;
  logic [7:0]  to_memory;
  logic        write;
  logic [7:0]  from_memory;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [31:0] port_out;
  logic [31:0] port_in;
  logic        rom_write_err;

  int checks = 0;
  int errors = 0;

  memory_system dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .to_memory     (to_memory),
    .write         (write),
    .from_memory   (from_memory),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .port_out      (port_out),
    .port_in       (port_in),
    .rom_write_err (rom_write_err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; address = 8'h00; to_memory = 8'h00; write = 1'b0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00; port_in = '0;

    // Reset with random bus activity
    for (int i = 0; i < 4; i++) begin
      address   = 8'($urandom);
      to_memory = 8'($urandom);
      write     = 1'b1;
      port_in   = $urandom;
      tick();
    end
    chk("reset_from_memory", {24'h0, from_memory}, 32'h0);
    chk("reset_port_out", port_out, 32'h0);
    chk("reset_rom_err", {31'h0, rom_write_err}, 32'h0);

    reset = 1'b0; write = 1'b0; port_in = '0; address = 8'h00;

    // Program ROM[0x10]=A5 and ROM[0x05]=12, then pulse reset between edges
    prog_we = 1'b1; prog_addr = 8'h10; prog_data = 8'hA5; tick();
    prog_addr = 8'h05; prog_data = 8'h12; tick();
    prog_we = 1'b0;
    reset = 1'b1; #2; reset = 1'b0;
    address = 8'h10; tick();
    chk("rom_retained", {24'h0, from_memory}, 32'hA5);

    // RAM write then read
    address = 8'h80; to_memory = 8'h3C; write = 1'b1; tick();
    write = 1'b0; tick();
    chk("ram_read_80", {24'h0, from_memory}, 32'h3C);

    // Read-before-write at 0x81
    address = 8'h81; to_memory = 8'h00; write = 1'b1; tick();
    to_memory = 8'h77; tick();
    chk("ram_rbw_old", {24'h0, from_memory}, 32'h00);
    write = 1'b0; tick();
    chk("ram_rbw_new", {24'h0, from_memory}, 32'h77);

    // ROM protection
    address = 8'h05; to_memory = 8'hFF; write = 1'b1; tick();
    chk("rom_err_set", {31'h0, rom_write_err}, 32'h1);
    write = 1'b0; tick();
    chk("rom_unchanged", {24'h0, from_memory}, 32'h12);
    chk("rom_err_sticky", {31'h0, rom_write_err}, 32'h1);

    // Programming above ROM_TOP does not touch RAM
    address = 8'h90; to_memory = 8'h44; write = 1'b1; tick();
    write = 1'b0;
    prog_we = 1'b1; prog_addr = 8'h90; prog_data = 8'hEE; tick();
    prog_we = 1'b0; tick();
    chk("prog_high_ignored", {24'h0, from_memory}, 32'h44);

    // CPU ROM write plus programming same address: programming wins
    address = 8'h20; to_memory = 8'h11; write = 1'b1;
    prog_we = 1'b1; prog_addr = 8'h20; prog_data = 8'h66; tick();
    write = 1'b0; prog_we = 1'b0; tick();
    chk("rom_prog_wins", {24'h0, from_memory}, 32'h66);

    // Output ports
    address = 8'hE2; to_memory = 8'h5A; write = 1'b1; tick();
    chk("port2_write", {24'h0, port_out[23:16]}, 32'h5A);
    write = 1'b0; tick();
    chk("port2_readback", {24'h0, from_memory}, 32'h5A);
    address = 8'hE7; to_memory = 8'h33; write = 1'b1; tick();
    chk("unmapped_out_write", port_out, 32'h005A_0000);
    write = 1'b0; tick();
    chk("unmapped_out_read", {24'h0, from_memory}, 32'h00);

    // Input synchronizer latency
    address = 8'hF0; tick();
    chk("sync_baseline", {24'h0, from_memory}, 32'h00);
    #3; port_in[7:0] = 8'hC3;
    tick();
    chk("sync_edge1", {24'h0, from_memory}, 32'h00);
    tick();
    chk("sync_edge2", {24'h0, from_memory}, 32'h00);
    tick();
    checks++;
    assert (from_memory === 8'h00 || from_memory === 8'hC3)
    else begin
      errors++;
      $error("FAIL sync_edge3 observed=%h expected=00 or C3", from_memory);
    end
    tick();
    chk("sync_edge4", {24'h0, from_memory}, 32'hC3);
    address = 8'hF9; tick();
    chk("unmapped_in_read", {24'h0, from_memory}, 32'h00);

    // Asynchronous reset during a port write
    address = 8'hE0; to_memory = 8'h42; write = 1'b1; tick();
    chk("port0_write", {24'h0, port_out[7:0]}, 32'h42);
    to_memory = 8'h99;
    #2; reset = 1'b1; #1;
    chk("async_port0_clear", {24'h0, port_out[7:0]}, 32'h00);
    chk("async_port2_clear", {24'h0, port_out[23:16]}, 32'h00);
    chk("async_err_clear", {31'h0, rom_write_err}, 32'h0);
    tick();
    reset = 1'b0; write = 1'b0; tick();
    chk("write_discarded", {24'h0, port_out[7:0]}, 32'h00);
    address = 8'h80; tick();
    chk("ram_retained", {24'h0, from_memory}, 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
